// File: rtl/univ_shift_register.sv
// Universal shift register: SIPO/PISO, left or right shifting, with frame tracking that
// counts BITS shifts after a parallel load and then pulses o_done for one cycle.
module univ_shift_register #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            i_nrst,
    input  logic            i_sclr,
    input  logic            i_load,
    input  logic [BITS-1:0] i_data,
    input  logic            i_en,
    input  logic            i_dir,
    input  logic            i_dat,
    output logic [BITS-1:0] o_data,
    output logic            o_sdat,
    output logic            o_busy,
    output logic            o_done
);

    localparam int unsigned CntW = $clog2(BITS);
    localparam logic [CntW-1:0] CntLast = CntW'(BITS - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [BITS-1:0] data_q, data_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (i_sclr) begin
            state_d = StIdle;
            count_d = '0;
            data_d  = '0;
        end else if (i_load) begin
            state_d = StShift;
            count_d = '0;
            data_d  = i_data;
        end else if (i_en) begin
            data_d = i_dir ? {i_dat, data_q[BITS-1:1]} : {data_q[BITS-2:0], i_dat};
            // Only a loaded frame is counted; free-running SIPO in idle leaves count at 0.
            if (state_q == StShift) begin
                if (count_q == CntLast) begin
                    state_d = StIdle;
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            state_q <= StIdle;
            count_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_data = data_q;
    assign o_sdat = i_dir ? data_q[0] : data_q[BITS-1];
    assign o_busy = (state_q == StShift);
    assign o_done = done_q;

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
- Parametrised universal shift register. Supports serial-in/parallel-out, parallel-load/serial-out, and left or right shifting.
- Adds frame tracking: after a parallel load it counts exactly BITS shifts, then pulses o_done.
- Used in the VGA path to serialise font and pixel rows and to deserialise serial config streams.
- With i_load held 0 and i_dir=0, it behaves as a plain shift-left register with sync clear.

Parameters:
- BITS, 8, register width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- i_nrst  input  1  reset, synchronous, active-low.
- i_sclr  input  1  synchronous clear, active-high.
- i_load  input  1  parallel load strobe; starts a frame.
- i_data  input  BITS  parallel load value.
- i_en  input  1  shift enable.
- i_dir  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
- i_dat  input  1  serial input bit, shifted into the vacated end.
- o_data  output  BITS  register contents.
- o_sdat  output  1  serial output, combinational: o_data[BITS-1] when i_dir=0, o_data[0] when i_dir=1.
- o_busy  output  1  high while a loaded frame is being shifted out.
- o_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Single clock. All registers update on posedge clk. Nothing is asynchronous except o_sdat.
- Priority per edge: i_nrst=0 > i_sclr=1 > i_load=1 > i_en=1 > hold.
- Reset (i_nrst=0 at an edge):
  - o_data=0, count=0, state=IDLE, o_busy=0, o_done=0.
  - Applies mid-frame too; the aborted frame produces no o_done.
- i_sclr=1: same effect as reset (o_data=0, IDLE, count=0, o_done=0).
- i_load=1:
  - o_data<=i_data, count<=0, state<=SHIFT, o_done<=0.
  - Load during SHIFT restarts the frame; the old frame gives no done.
  - i_en is ignored on that edge.
- Shift on i_en=1 (no higher-priority input):
  - Left: o_data<={o_data[BITS-2:0], i_dat}.
  - Right: o_data<={i_dat, o_data[BITS-1:1]}.
  - i_dir is sampled on each shift edge. A direction change mid-frame applies immediately and does not affect count.
- State machine, states IDLE and SHIFT; o_busy = (state==SHIFT), registered.
  - IDLE: shifts are allowed (free-running SIPO), count stays 0, no o_done ever.
  - SHIFT: each shift increments count.
  - On the edge performing the BITS-th shift (count==BITS-1): state<=IDLE, count<=0, o_done<=1.
  - i_en=0 holds both o_data and count; gaps of any length are allowed.
- o_done is high exactly one cycle after the completing edge and cleared on the next edge, unconditionally.
- count width is $clog2(BITS). It never exceeds BITS-1, so there is no wrap.
- o_sdat shows the next bit to leave the register: the first bit is valid right after the load edge, and the next bit after each shift edge.

Test Plan (BITS=5):
1. Reset: hold i_nrst=0 across one edge with random inputs -> o_data=00000, o_busy=0, o_done=0. Release -> state unchanged until a stimulus arrives.
2. SIPO left: i_sclr pulse, then i_en=1, i_dir=0, i_dat=1,0,1,1,1,1,0 on successive edges -> o_data=00001, 00010, 00101, 01011, 10111, 01111, 11110. o_busy and o_done stay 0 throughout.
3. PISO left: load 10110, then 5 shifts with i_dat=0 -> o_busy=1 after load. o_sdat before each shift = 1, 0, 1, 1, 0. o_data=00000 after the 5th shift. o_done=1 for exactly that one cycle, with o_busy=0 at the same time.
4. PISO right: load 10110, i_dir=1, i_dat=1, 5 shifts -> o_sdat = 0, 1, 1, 0, 1. Final o_data=11111, o_done pulses once.
5. Enable gaps: load 10110, 2 shifts, i_en=0 for 3 cycles (o_data=11000 held, o_busy=1), then 3 more shifts -> o_done only after the 5th shift in total.
6. Priority and abort:
   - i_load and i_en high on the same edge -> o_data=i_data, count=0.
   - 3 shifts into a frame, assert i_sclr -> o_data=0, o_busy=0, no o_done.
   - Repeat the abort with i_nrst=0 -> same result.
   - Reload at shift 4 -> o_done only 5 shifts after the reload.
